tower_stage_ctrl: RTL and testbench
===================================

# tower_stage_ctrl

Game-level sequencer that sits directly upstream of the tower placement block. It drives the one-hot `stage_N_draw_tower` enables and consumes the matching `stage_N_tower_done` feedback. Between build phases it launches and tracks enemy waves and counts lives. It declares win after stage 3 or loss when lives reach zero.

## Interface
Parameters:
- `LIVES_INIT`, 5: lives loaded at reset and on game (re)start; 1..15.
- `PAUSE_CYCLES`, 50_000_000: cycles spent in PAUSE between build and wave; ≥1, fits 26 bits.

Ports:
- `clk` in 1: system clock; all state changes on rising edge.
- `resetn` in 1: asynchronous active-low reset.
- `go_start` in 1: start/restart request, level; internally rising-edge detected.
- `stage_1_tower_done`, `stage_2_tower_done`, `stage_3_tower_done` in 1 each: build-phase completion from the tower block, sampled as level.
- `wave_done` in 1: enemy wave finished, level, sampled only in WAVE.
- `enemy_escaped` in 1: one-cycle pulse per enemy reaching base.
- `stage_1_draw_tower`, `stage_2_draw_tower`, `stage_3_draw_tower` out 1 each: registered, at most one high.
- `wave_start` out 1: one-cycle pulse on WAVE entry.
- `wave_active` out 1: high throughout WAVE.
- `current_stage` out 2: 0 when idle, 1..3 during play, and holds its value in WON/LOST.
- `lives` out 4: remaining lives.
- `game_won` out 1, `game_over` out 1: high while in WON / LOST respectively.

## Operation
- States: IDLE, BUILD, PAUSE, WAVE, WON, LOST. All outputs are registered.
- IDLE: all enables low. A `go_start` rising edge loads `lives`=LIVES_INIT and sets `current_stage`=1, then goes to BUILD.
- BUILD: `stage_<current_stage>_draw_tower`=1. When the matching `stage_N_tower_done`=1, it goes to PAUSE with the pause counter cleared. The done inputs of other stages are ignored.
- PAUSE: enables low. The counter increments each cycle. On the cycle where the count equals PAUSE_CYCLES−1, it goes to WAVE.
- WAVE: `wave_start` is high on the first cycle only, and `wave_active` stays high.
  - Each `enemy_escaped` decrements `lives`, saturating at 0.
  - If the decrement makes `lives` 0, the next state is LOST.
  - Otherwise, on `wave_done`: if `current_stage`=3, go to WON; else increment the stage and go to BUILD.
- Simultaneous `enemy_escaped` and `wave_done` with `lives`=1: LOST wins. With `lives`>1, the decrement applies and the stage advances.
- `enemy_escaped` outside WAVE is ignored.
- WON/LOST: `game_won`/`game_over` stays high. A `go_start` rising edge restarts exactly as from IDLE (lives reload, stage 1, BUILD).
- A `go_start` edge in BUILD/PAUSE/WAVE is ignored.
- The edge detector register resets to 1, so a key held through reset does not start the game.

## Timing
- Reset values:
  - state IDLE
  - `lives`=LIVES_INIT
  - `current_stage`=0
  - all draw enables, `wave_start`, `wave_active`, `game_won`, `game_over` = 0
- Reset mid-operation returns to IDLE immediately and asynchronously; nothing is retained.
- `go_start` rise sampled at edge N: the draw enable is high after edge N+1 (one cycle for edge detect).
- Done sampled at edge N: the enable is low after edge N. `wave_start` is high after edge N+PAUSE_CYCLES, for exactly 1 cycle.
- `wave_done` sampled at edge N: the next stage's enable is high after edge N; `wave_active` is low after edge N.
- `enemy_escaped` at edge N: `lives` is updated after edge N.

## Configuration
- `TOWER_STAGE_LIFE_BONUS_EN`
  - Defined: on each WAVE→BUILD transition, `lives` increments by 1, saturating at LIVES_INIT. This is applied after any same-cycle escape decrement.
  - Undefined: lives never increase during a game.

## Test plan
All scenarios use LIVES_INIT=3, PAUSE_CYCLES=4.
- Reset, pulse `go_start` -> `stage_1_draw_tower`=1 two cycles after rise, `current_stage`=1, `lives`=3.
- In BUILD stage 1, raise `stage_1_tower_done` -> enable low next cycle. `wave_start` pulses exactly 4 cycles after done is sampled. `stage_2_tower_done` asserted during stage 1 has no effect.
- Full run with three builds and three `wave_done`s, no escapes -> `game_won`=1, `current_stage`=3, `lives`=3. A further `go_start` returns to BUILD stage 1.
- Stage 1 wave, 3 `enemy_escaped` pulses -> `lives` 2,1,0 and `game_over`=1. Extra pulses leave `lives`=0.
- `lives`=1, `enemy_escaped` and `wave_done` in the same cycle -> LOST, not stage 2.
- With the macro: escape to `lives`=2, then `wave_done` -> `lives`=3. Without it -> `lives` stays 2. Reset asserted in WAVE -> all outputs at reset values in the same cycle.

Source files
------------

// File: rtl/tower_stage_ctrl.sv
// tower_stage_ctrl
//   Game-level sequencer sitting upstream of the tower placement block.
//   Walks IDLE -> BUILD -> PAUSE -> WAVE for stages 1..3, counts lives
//   during waves, and ends in WON (after stage 3) or LOST (lives hit 0).
//   WON/LOST restart on a fresh go_start rising edge.
//
// Parameters
//   LIVES_INIT   : lives loaded at reset and on every (re)start, 1..15
//   PAUSE_CYCLES : cycles spent in PAUSE between build and wave, >= 1
//
// Ports
//   clk, resetn                 : clock, asynchronous active-low reset
//   go_start                    : start/restart request (level, edge detected)
//   stage_N_tower_done (N=1..3) : build completion from tower block
//   wave_done, enemy_escaped    : wave finished / enemy reached base (pulse)
//   stage_N_draw_tower (N=1..3) : one-hot build enables (registered)
//   wave_start, wave_active     : WAVE entry pulse / WAVE level
//   current_stage, lives        : game progress
//   game_won, game_over         : high in WON / LOST
//
// Build option
//   TOWER_STAGE_LIFE_BONUS_EN : when defined, every WAVE->BUILD transition
//   grants one life (after any same-cycle escape), saturating at LIVES_INIT.

module tower_stage_ctrl #(
  parameter int LIVES_INIT   = 5,
  parameter int PAUSE_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       go_start,
  input  logic       stage_1_tower_done,
  input  logic       stage_2_tower_done,
  input  logic       stage_3_tower_done,
  input  logic       wave_done,
  input  logic       enemy_escaped,
  output logic       stage_1_draw_tower,
  output logic       stage_2_draw_tower,
  output logic       stage_3_draw_tower,
  output logic       wave_start,
  output logic       wave_active,
  output logic [1:0] current_stage,
  output logic [3:0] lives,
  output logic       game_won,
  output logic       game_over
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_BUILD = 3'd1;
  localparam logic [2:0] ST_PAUSE = 3'd2;
  localparam logic [2:0] ST_WAVE  = 3'd3;
  localparam logic [2:0] ST_WON   = 3'd4;
  localparam logic [2:0] ST_LOST  = 3'd5;

  localparam logic [3:0]  LIVES_RST  = 4'(LIVES_INIT);
  localparam logic [25:0] PAUSE_LAST = 26'(PAUSE_CYCLES - 1);

  logic [2:0]  state_q, state_d;
  logic [1:0]  stage_q, stage_d;
  logic [3:0]  lives_q, lives_d;
  logic [25:0] cnt_q, cnt_d;
  logic [2:0]  draw_q, draw_d;
  logic        wave_start_q, wave_start_d;
  logic        wave_active_q, wave_active_d;
  logic        won_q, won_d;
  logic        over_q, over_d;

  // go_start passes through a sample stage before edge detection; both
  // flops reset high so a key held through reset is not seen as a rise.
  logic go_sync_q, go_prev_q;
  logic go_rise_s;
  logic done_sel_s;
  logic [3:0] lives_dec_s;

  assign go_rise_s = go_sync_q & ~go_prev_q;

  // Synchronise go_start and keep its previous value for edge detection
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      go_sync_q <= 1'b1;
      go_prev_q <= 1'b1;
    end else begin
      go_sync_q <= go_start;
      go_prev_q <= go_sync_q;
    end
  end

  // Select the done input matching the stage currently being built
  always_comb begin
    done_sel_s = 1'b0;
    case (stage_q)
      2'd1:    done_sel_s = stage_1_tower_done;
      2'd2:    done_sel_s = stage_2_tower_done;
      2'd3:    done_sel_s = stage_3_tower_done;
      default: done_sel_s = 1'b0;
    endcase
  end

  // Lives after a possible escape this cycle, saturating at zero
  always_comb begin
    lives_dec_s = lives_q;
    if (enemy_escaped && (lives_q != 4'd0)) begin
      lives_dec_s = lives_q - 4'd1;
    end else begin
      lives_dec_s = lives_q;
    end
  end

  // Next-state and next-value logic for the game sequencer
  always_comb begin
    state_d      = state_q;
    stage_d      = stage_q;
    lives_d      = lives_q;
    cnt_d        = cnt_q;
    wave_start_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_WON, ST_LOST: begin
        if (go_rise_s) begin
          state_d = ST_BUILD;
          stage_d = 2'd1;
          lives_d = LIVES_RST;
        end else begin
          state_d = state_q;
        end
      end
      ST_BUILD: begin
        if (done_sel_s) begin
          state_d = ST_PAUSE;
          cnt_d   = 26'd0;
        end else begin
          state_d = ST_BUILD;
        end
      end
      ST_PAUSE: begin
        if (cnt_q == PAUSE_LAST) begin
          state_d      = ST_WAVE;
          wave_start_d = 1'b1;
          cnt_d        = 26'd0;
        end else begin
          cnt_d = cnt_q + 26'd1;
        end
      end
      ST_WAVE: begin
        lives_d = lives_dec_s;
        // Losing the last life takes priority over finishing the wave.
        if (enemy_escaped && (lives_dec_s == 4'd0)) begin
          state_d = ST_LOST;
        end else if (wave_done) begin
          if (stage_q == 2'd3) begin
            state_d = ST_WON;
          end else begin
            state_d = ST_BUILD;
            stage_d = stage_q + 2'd1;
`ifdef TOWER_STAGE_LIFE_BONUS_EN
            if (lives_dec_s < LIVES_RST) begin
              lives_d = lives_dec_s + 4'd1;
            end else begin
              lives_d = lives_dec_s;
            end
`else
            lives_d = lives_dec_s;
`endif
          end
        end else begin
          state_d = ST_WAVE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        stage_d = 2'd0;
        lives_d = LIVES_RST;
        cnt_d   = 26'd0;
      end
    endcase
  end

  // Output values are decoded from the next state so they register with it
  always_comb begin
    draw_d = 3'b000;
    if (state_d == ST_BUILD) begin
      case (stage_d)
        2'd1:    draw_d = 3'b001;
        2'd2:    draw_d = 3'b010;
        2'd3:    draw_d = 3'b100;
        default: draw_d = 3'b000;
      endcase
    end else begin
      draw_d = 3'b000;
    end
    wave_active_d = (state_d == ST_WAVE);
    won_d         = (state_d == ST_WON);
    over_d        = (state_d == ST_LOST);
  end

  // State and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      stage_q       <= 2'd0;
      lives_q       <= LIVES_RST;
      cnt_q         <= 26'd0;
      draw_q        <= 3'b000;
      wave_start_q  <= 1'b0;
      wave_active_q <= 1'b0;
      won_q         <= 1'b0;
      over_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      stage_q       <= stage_d;
      lives_q       <= lives_d;
      cnt_q         <= cnt_d;
      draw_q        <= draw_d;
      wave_start_q  <= wave_start_d;
      wave_active_q <= wave_active_d;
      won_q         <= won_d;
      over_q        <= over_d;
    end
  end

  assign stage_1_draw_tower = draw_q[0];
  assign stage_2_draw_tower = draw_q[1];
  assign stage_3_draw_tower = draw_q[2];
  assign wave_start         = wave_start_q;
  assign wave_active        = wave_active_q;
  assign current_stage      = stage_q;
  assign lives              = lives_q;
  assign game_won           = won_q;
  assign game_over          = over_q;

endmodule

// File: tb/tb_tower_stage_ctrl.sv
// Directed self-checking bench for tower_stage_ctrl (LIVES_INIT=3, PAUSE_CYCLES=4).
module tb_tower_stage_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic       go_start;
  logic       d1, d2, d3;
  logic       wave_done;
  logic       enemy_escaped;
  logic       draw1, draw2, draw3;
  logic       wave_start;
  logic       wave_active;
  logic [1:0] current_stage;
  logic [3:0] lives;
  logic       game_won;
  logic       game_over;

  int checks   = 0;
  int failures = 0;

  tower_stage_ctrl #(.LIVES_INIT(3), .PAUSE_CYCLES(4)) dut (
    .clk                (clk),
    .resetn             (resetn),
    .go_start           (go_start),
    .stage_1_tower_done (d1),
    .stage_2_tower_done (d2),
    .stage_3_tower_done (d3),
    .wave_done          (wave_done),
    .enemy_escaped      (enemy_escaped),
    .stage_1_draw_tower (draw1),
    .stage_2_draw_tower (draw2),
    .stage_3_draw_tower (draw3),
    .wave_start         (wave_start),
    .wave_active        (wave_active),
    .current_stage      (current_stage),
    .lives              (lives),
    .game_won           (game_won),
    .game_over          (game_over)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] draws();
    return {draw3, draw2, draw1};
  endfunction

  // Rising edge on go_start: draw enable appears two edges after the rise is applied
  task automatic start_game();
    go_start = 1'b1;
    tick();
    check_val("start_latency", {29'd0, draws()}, 32'd0);
    tick();
    go_start = 1'b0;
    check_val("start_draw1", {29'd0, draws()}, 32'd1);
    check_val("start_stage", {30'd0, current_stage}, 32'd1);
    check_val("start_lives", {28'd0, lives}, 32'd3);
  endtask

  // Complete the build of stage n and run through PAUSE into the first WAVE cycle
  task automatic do_build(input int n);
    if (n == 1) d1 = 1'b1; else if (n == 2) d2 = 1'b1; else d3 = 1'b1;
    tick();
    d1 = 1'b0; d2 = 1'b0; d3 = 1'b0;
    check_val("build_draw_off", {29'd0, draws()}, 32'd0);
    repeat (3) begin
      tick();
      check_val("pause_no_wave", {31'd0, wave_start}, 32'd0);
    end
    tick();
    check_val("wave_start_pulse", {31'd0, wave_start}, 32'd1);
    check_val("wave_active_on", {31'd0, wave_active}, 32'd1);
  endtask

  task automatic escape();
    enemy_escaped = 1'b1;
    tick();
    enemy_escaped = 1'b0;
  endtask

  task automatic finish_wave();
    wave_done = 1'b1;
    tick();
    wave_done = 1'b0;
  endtask

  initial begin
    logic [3:0] bonus_exp;
    resetn = 1'b0; go_start = 1'b0; d1 = 1'b0; d2 = 1'b0; d3 = 1'b0;
    wave_done = 1'b0; enemy_escaped = 1'b0;
    #12;
    resetn = 1'b1;
    tick();
    tick();
    check_val("rst_draws", {29'd0, draws()}, 32'd0);
    check_val("rst_stage", {30'd0, current_stage}, 32'd0);
    check_val("rst_lives", {28'd0, lives}, 32'd3);
    check_val("rst_flags", {28'd0, wave_start, wave_active, game_won, game_over}, 32'd0);

    // Scenario: stage 1 build, wrong-stage done ignored, full win run
    start_game();
    d2 = 1'b1;
    tick();
    d2 = 1'b0;
    check_val("wrong_done_ignored", {29'd0, draws()}, 32'd1);
    do_build(1);
    tick();
    check_val("wave_start_once", {31'd0, wave_start}, 32'd0);
    check_val("wave_active_hold", {31'd0, wave_active}, 32'd1);
    finish_wave();
    check_val("stage2_draw", {29'd0, draws()}, 32'd2);
    check_val("stage2_num", {30'd0, current_stage}, 32'd2);
    check_val("wave_active_off", {31'd0, wave_active}, 32'd0);
    do_build(2);
    finish_wave();
    check_val("stage3_draw", {29'd0, draws()}, 32'd4);
    do_build(3);
    finish_wave();
    check_val("won_flag", {31'd0, game_won}, 32'd1);
    check_val("won_stage", {30'd0, current_stage}, 32'd3);
    check_val("won_lives", {28'd0, lives}, 32'd3);
    check_val("won_draws", {29'd0, draws()}, 32'd0);
    tick();
    start_game();
    check_val("restart_won_clr", {31'd0, game_won}, 32'd0);

    // Scenario: three escapes lose the game; extra escapes saturate
    do_build(1);
    escape();
    check_val("esc_lives2", {28'd0, lives}, 32'd2);
    escape();
    check_val("esc_lives1", {28'd0, lives}, 32'd1);
    check_val("esc_not_over", {31'd0, game_over}, 32'd0);
    escape();
    check_val("esc_lives0", {28'd0, lives}, 32'd0);
    check_val("lost_flag", {31'd0, game_over}, 32'd1);
    escape();
    check_val("esc_saturate", {28'd0, lives}, 32'd0);
    check_val("lost_stays", {31'd0, game_over}, 32'd1);

    // Scenario: last life and wave_done together -> LOST
    tick();
    start_game();
    check_val("restart_over_clr", {31'd0, game_over}, 32'd0);
    do_build(1);
    escape();
    escape();
    check_val("tie_lives1", {28'd0, lives}, 32'd1);
    enemy_escaped = 1'b1;
    wave_done = 1'b1;
    tick();
    enemy_escaped = 1'b0;
    wave_done = 1'b0;
    check_val("tie_lost", {31'd0, game_over}, 32'd1);
    check_val("tie_stage", {30'd0, current_stage}, 32'd1);
    check_val("tie_no_draw", {29'd0, draws()}, 32'd0);

    // Scenario: life bonus (build-option dependent) and asynchronous reset in WAVE
    tick();
    start_game();
    do_build(1);
    escape();
    check_val("bonus_pre", {28'd0, lives}, 32'd2);
    finish_wave();
`ifdef TOWER_STAGE_LIFE_BONUS_EN
    bonus_exp = 4'd3;
`else
    bonus_exp = 4'd2;
`endif
    check_val("bonus_lives", {28'd0, lives}, {28'd0, bonus_exp});
    check_val("bonus_stage", {30'd0, current_stage}, 32'd2);
    do_build(2);
    resetn = 1'b0;
    #1;
    check_val("async_rst_active", {31'd0, wave_active}, 32'd0);
    check_val("async_rst_stage", {30'd0, current_stage}, 32'd0);
    check_val("async_rst_lives", {28'd0, lives}, 32'd3);
    check_val("async_rst_flags", {26'd0, draws(), wave_start, game_won, game_over}, 32'd0);
    resetn = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
